// File: rtl/riscv_memmisaligned_split.sv
// Splits a CPU data access that crosses a word boundary into two aligned
// memory beats and merges the read data back. Accesses that fit in one word
// pass through as a single beat with byte enables.
module riscv_memmisaligned_split #(
  parameter int XLEN = 32,
  parameter int PLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [PLEN-1:0]   adr_i,
  input  logic [2:0]        size_i,
  input  logic              we_i,
  input  logic [XLEN-1:0]   d_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [XLEN-1:0]   q_o,
  output logic              mem_req_o,
  output logic [PLEN-1:0]   mem_adr_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_d_o,
  input  logic              mem_ack_i,
  input  logic              mem_err_i,
  input  logic [XLEN-1:0]   mem_q_i
);

  localparam int unsigned WB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(WB);

  // access size encodings on size_i
  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HWORD = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_DWORD = 3'b011;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state, state_nxt;
  int unsigned       nbytes;
  logic              illegal_in;
  logic [OFFW-1:0]   off_in, off_r;
  logic [2*WB-1:0]   mask_in, be2_in, be2_r;
  logic [2*XLEN-1:0] d2_in, d2_r, merged;
  logic [WB-1:0]     qmask_r;
  logic [PLEN-1:0]   adr_r;
  logic              we_r, illegal_r, err_r, split_r;
  logic [XLEN-1:0]   q0_r, q1_r;

  // Decode the incoming request: byte mask, lane-shifted enables and data
  always_comb begin
    off_in     = adr_i[OFFW-1:0];
    nbytes     = 0;
    illegal_in = 1'b0;
    case (size_i)
      SZ_BYTE:  nbytes = 1;
      SZ_HWORD: nbytes = 2;
      SZ_WORD:  nbytes = 4;
      SZ_DWORD: if (XLEN == 64) nbytes = 8; else illegal_in = 1'b1;
      default:  illegal_in = 1'b1;
    endcase
    for (int unsigned i = 0; i < 2*WB; i++) mask_in[i] = (i < nbytes);
    be2_in = mask_in << off_in;
    d2_in  = {{XLEN{1'b0}}, d_i} << {off_in, 3'b000};
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch, beat read-data capture and error status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_r     <= '0;
      off_r     <= '0;
      be2_r     <= '0;
      d2_r      <= '0;
      qmask_r   <= '0;
      we_r      <= 1'b0;
      illegal_r <= 1'b0;
      split_r   <= 1'b0;
      err_r     <= 1'b0;
      q0_r      <= '0;
      q1_r      <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          adr_r     <= adr_i & ~PLEN'(WB - 1);
          off_r     <= off_in;
          be2_r     <= be2_in;
          d2_r      <= d2_in;
          qmask_r   <= mask_in[WB-1:0];
          we_r      <= we_i;
          illegal_r <= illegal_in;
          split_r   <= |be2_in[2*WB-1:WB];
          err_r     <= 1'b0;
          q0_r      <= '0;
          q1_r      <= '0;
        end
        BEAT0: begin
          if (illegal_r || mem_err_i) err_r <= 1'b1;
          else if (mem_ack_i)         q0_r  <= mem_q_i;
        end
        BEAT1: begin
          if (mem_err_i)      err_r <= 1'b1;
          else if (mem_ack_i) q1_r  <= mem_q_i;
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs. An illegal size still passes through BEAT0 with
  // the memory request suppressed, so its error response keeps the same
  // two-cycle timing as a single-beat access.
  always_comb begin
    state_nxt = state;
    ack_o     = 1'b0;
    err_o     = 1'b0;
    q_o       = '0;
    mem_req_o = 1'b0;
    mem_adr_o = '0;
    mem_we_o  = 1'b0;
    mem_be_o  = '0;
    mem_d_o   = '0;
    merged    = {q1_r, q0_r} >> {off_r, 3'b000};
    case (state)
      IDLE: if (req_i) state_nxt = BEAT0;
      BEAT0: begin
        if (illegal_r) begin
          state_nxt = RESP;
        end else begin
          mem_req_o = 1'b1;
          mem_adr_o = adr_r;
          mem_we_o  = we_r;
          mem_be_o  = be2_r[WB-1:0];
          mem_d_o   = d2_r[XLEN-1:0];
          if (mem_err_i)      state_nxt = RESP;
          else if (mem_ack_i) state_nxt = split_r ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        mem_req_o = 1'b1;
        mem_adr_o = adr_r + PLEN'(WB);
        mem_we_o  = we_r;
        mem_be_o  = be2_r[2*WB-1:WB];
        mem_d_o   = d2_r[2*XLEN-1:XLEN];
        if (mem_err_i || mem_ack_i) state_nxt = RESP;
      end
      RESP: begin
        ack_o     = 1'b1;
        err_o     = err_r;
        state_nxt = IDLE;
        if (!we_r && !err_r)
          for (int unsigned i = 0; i < WB; i++)
            q_o[8*i +: 8] = qmask_r[i] ? merged[8*i +: 8] : 8'h00;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_memmisaligned_split.sv
// Directed and randomized bench for riscv_memmisaligned_split with a
// byte-array memory (configurable wait states, error and stall injection).
module tb_riscv_memmisaligned_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] adr, dat;
  logic [2:0]  size;
  logic        ack_o, err_o, mem_req_o, mem_we_o, mem_ack_i, mem_err_i;
  logic [31:0] q_o, mem_adr_o, mem_d_o, mem_q_i;
  logic [3:0]  mem_be_o;

  int n_cmp = 0;
  int n_bad = 0;

  int wait_n     = 0;
  int err_beat   = -1;
  int stall_beat = -1;
  logic err_both = 1'b0;
  int beat_idx   = 0;
  int wcnt       = 0;
  logic inited   = 1'b0;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] log_adr[$];
  logic [3:0]  log_be[$];
  logic [31:0] log_d[$];

  always #5 clk = ~clk;

  riscv_memmisaligned_split #(.XLEN(32), .PLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .adr_i(adr), .size_i(size),
    .we_i(we), .d_i(dat), .ack_o(ack_o), .err_o(err_o), .q_o(q_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_d_o(mem_d_o), .mem_ack_i(mem_ack_i),
    .mem_err_i(mem_err_i), .mem_q_i(mem_q_i)
  );

  function automatic logic [7:0] init_byte(int a);
    if (a >= 32'h1000 && a < 32'h1008) return 8'((a - 32'h0fff) * 17);
    if (a >= 32'h3000 && a < 32'h3004) return 8'(8'hD4 - 8'h11 * (a - 32'h3000));
    return 8'((a * 37) ^ (a >> 7));
  endfunction

  // Memory side: zero-wait unless wait_n > 0; error/stall per beat index
  assign mem_err_i = mem_req_o && (beat_idx == err_beat);
  assign mem_ack_i = mem_req_o && (beat_idx != stall_beat) && (wcnt >= wait_n) &&
                     (!(beat_idx == err_beat) || err_both);

  always_comb
    for (int b = 0; b < 4; b++) mem_q_i[8*b +: 8] = mem[mem_adr_o[15:0] + 16'(b)];

  always @(posedge clk) begin
    if (!inited) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_byte(a);
      inited <= 1'b1;
    end else if (!rst && mem_req_o && mem_ack_i && !mem_err_i && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_adr_o[15:0] + 16'(b)] <= mem_d_o[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!rst && mem_req_o && (mem_ack_i || mem_err_i)) begin
      log_adr.push_back(mem_adr_o);
      log_be.push_back(mem_be_o);
      log_d.push_back(mem_d_o);
    end
    if (rst || ack_o) beat_idx <= 0;
    else if (mem_req_o && (mem_ack_i || mem_err_i)) beat_idx <= beat_idx + 1;
    if (rst || !mem_req_o || mem_ack_i || mem_err_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes_of(logic [2:0] sz);
    return (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
  endfunction

  task automatic do_access(input logic [31:0] a, input logic [2:0] sz, input logic w,
                           input logic [31:0] d, output logic [31:0] q,
                           output logic e, output int cyc);
    req = 1'b1; adr = a; size = sz; we = w; dat = d;
    cyc = 0; q = '0; e = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (ack_o) begin cyc = n; q = q_o; e = err_o; break; end
    end
    req = 1'b0;
    if (cyc == 0) check("ack_timeout", 0, 1);
    else if (w && !e)
      for (int b = 0; b < nbytes_of(sz); b++) ref_mem[16'(a + b)] = d[8*b +: 8];
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  logic [31:0] q, a, d, exp;
  logic        e, w, found;
  logic [2:0]  sz;
  int          cyc, n0, acks;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    rst = 1'b1; req = 1'b0; we = 1'b0; adr = '0; dat = '0; size = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_be", mem_be_o, 0);
    check("rst_mem_adr", mem_adr_o, 0);
    check("rst_q", q_o, 0);
    rst = 1'b0;
    idle_cycle();

    // 1: split WORD read at 0x1003
    n0 = log_adr.size();
    do_access(32'h1003, 3'd2, 1'b0, 32'h0, q, e, cyc);
    check("t1_q", q, 32'h77665544);
    check("t1_err", e, 0);
    check("t1_cycles", cyc, 3);
    check("t1_beats", log_adr.size() - n0, 2);
    check("t1_adr0", log_adr[n0], 32'h1000);
    check("t1_be0", log_be[n0], 4'b1000);
    check("t1_adr1", log_adr[n0+1], 32'h1004);
    check("t1_be1", log_be[n0+1], 4'b0111);

    // 2: split HWORD write 0xBEEF at 0x2003, then read back
    idle_cycle();
    n0 = log_adr.size();
    do_access(32'h2003, 3'd1, 1'b1, 32'h0000BEEF, q, e, cyc);
    check("t2_q_write", q, 0);
    check("t2_beats", log_adr.size() - n0, 2);
    check("t2_adr0", log_adr[n0], 32'h2000);
    check("t2_be0", log_be[n0], 4'b1000);
    check("t2_d0", log_d[n0], 32'hEF000000);
    check("t2_adr1", log_adr[n0+1], 32'h2004);
    check("t2_be1", log_be[n0+1], 4'b0001);
    check("t2_d1", log_d[n0+1] & 32'h000000FF, 32'h000000BE);
    do_access(32'h2003, 3'd1, 1'b0, 32'h0, q, e, cyc);
    check("t2_readback", q, 32'h0000BEEF);

    // 3: single-beat accesses
    idle_cycle();
    n0 = log_adr.size();
    do_access(32'h3000, 3'd2, 1'b0, 32'h0, q, e, cyc);
    check("t3_q", q, 32'hA1B2C3D4);
    check("t3_cycles", cyc, 2);
    check("t3_beats", log_adr.size() - n0, 1);
    check("t3_be", log_be[n0], 4'b1111);
    n0 = log_adr.size();
    do_access(32'h1001, 3'd1, 1'b0, 32'h0, q, e, cyc);
    check("t3_hw_q", q, 32'h00003322);
    check("t3_hw_beats", log_adr.size() - n0, 1);
    check("t3_hw_be", log_be[n0], 4'b0110);

    // 4: errors
    err_beat = 0;
    n0 = log_adr.size();
    do_access(32'h1003, 3'd2, 1'b0, 32'h0, q, e, cyc);
    check("t4_err_beat0", e, 1);
    check("t4_err_beats", log_adr.size() - n0, 1);
    err_both = 1'b1;
    n0 = log_adr.size();
    do_access(32'h1003, 3'd2, 1'b0, 32'h0, q, e, cyc);
    check("t4_both_err", e, 1);
    check("t4_both_beats", log_adr.size() - n0, 1);
    err_beat = 1;
    do_access(32'h1003, 3'd2, 1'b0, 32'h0, q, e, cyc);
    check("t4_both_beat1_err", e, 1);
    err_beat = -1; err_both = 1'b0;
    idle_cycle();
    n0 = log_adr.size();
    do_access(32'h1000, 3'd3, 1'b0, 32'h0, q, e, cyc);
    check("t4_dword_err", e, 1);
    check("t4_dword_cycles", cyc, 2);
    check("t4_dword_beats", log_adr.size() - n0, 0);
    do_access(32'h1000, 3'd7, 1'b0, 32'h0, q, e, cyc);
    check("t4_undef_err", e, 1);

    // 5: reset while beat1 stalls
    stall_beat = 1;
    req = 1'b1; adr = 32'h1003; size = 3'd2; we = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge clk); #1;
      if (mem_req_o && mem_adr_o == 32'h1004) found = 1'b1;
    end
    check("t5_reach_beat1", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_mem_req_drop", mem_req_o, 0);
    check("t5_ack_in_rst", ack_o, 0);
    rst = 1'b0; req = 1'b0; stall_beat = -1;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_o) acks++;
    end
    check("t5_no_ack", acks, 0);
    do_access(32'h1003, 3'd2, 1'b0, 32'h0, q, e, cyc);
    check("t5_after_q", q, 32'h77665544);
    check("t5_after_err", e, 0);

    // 6: random sweep, back-to-back with random wait states
    for (int i = 0; i < 80; i++) begin
      sz = 3'($urandom_range(0, 2));
      a  = 32'h4000 + $urandom_range(0, 255);
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      wait_n = $urandom_range(0, 2);
      exp = '0;
      if (!w)
        for (int b = 0; b < nbytes_of(sz); b++) exp[8*b +: 8] = ref_mem[16'(a + b)];
      do_access(a, sz, w, d, q, e, cyc);
      check("t6_q", q, exp);
      check("t6_err", e, 0);
    end
    wait_n = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
